cam_capture: RTL

- Camera pixel capture stage: consumes raw 8-bit DVP camera bus (PCLK/VSYNC/HREF/D) from GPIO_0 once the camera has been configured over I2C.
- Produces RGB565 pixels with x/y coordinates and frame/line markers for the downstream frame buffer feeding the HDMI output path.
- Single system clock; camera signals are treated as asynchronous and oversampled. PCLK is never used as a clock.

---
 rtl/cam_pkg.sv | 26 ++
 rtl/cam_sync_edge.sv | 50 +++++
 rtl/cam_capture.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/cam_pkg.sv
// Shared types and constants for the DVP camera capture stage.
package cam_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int X_W          = 10;
  localparam int Y_W          = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_CAPTURE = 2'd2
  } cam_state_e;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // First camera byte lands in the upper half of the pixel word.
  function automatic rgb565_t pack_rgb565(input logic [7:0] hi, input logic [7:0] lo);
    return rgb565_t'({hi, lo});
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Synchroniser chain for a bundle of asynchronous camera signals, followed by
// a registered level plus rise/fall pulses that all describe the same sample.
module cam_sync_edge
  import cam_pkg::*;
#(
  parameter int W      = 11,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_async,
  output logic [W-1:0] o_level,
  output logic [W-1:0] o_rise,
  output logic [W-1:0] o_fall
);

  logic [W-1:0] r_sync [STAGES];
  logic [W-1:0] r_q;
  logic [W-1:0] r_rise;
  logic [W-1:0] r_fall;

  // Metastability chain: every bit passes through STAGES flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= i_async;
      for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // Edge detection: level and edge pulses are registered together so that
  // data/href/vsync stay aligned with the pclk edge they accompany.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_q    <= r_sync[STAGES-1];
      r_rise <= r_sync[STAGES-1] & ~r_q;
      r_fall <= ~r_sync[STAGES-1] & r_q;
    end
  end

  assign o_level = r_q;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/cam_capture.sv
// DVP camera capture: oversamples PCLK/HREF/VSYNC/D on the system clock and
// assembles RGB565 pixels with coordinates and frame/line markers.
// Optional CAM_CAPTURE_STATS_EN adds frame_cnt and last_line_cnt outputs.
module cam_capture
  import cam_pkg::*;
#(
  parameter int H_ACTIVE       = H_ACTIVE_DEF,
  parameter int V_ACTIVE       = V_ACTIVE_DEF,
  parameter int SYNC_STAGES    = 2,
  parameter int VS_ACTIVE_HIGH = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic           cam_pclk,
  input  logic           cam_vsync,
  input  logic           cam_href,
  input  logic [7:0]     cam_d,
  output logic           pix_valid,
  output logic [15:0]    pix_data,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic           sof,
  output logic           eol,
  output logic           frame_done,
  output logic           line_err
`ifdef CAM_CAPTURE_STATS_EN
  ,
  output logic [15:0]    frame_cnt,
  output logic [9:0]     last_line_cnt
`endif
);

  localparam logic [X_W-1:0] X_MAX  = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] Y_MAX  = Y_W'(V_ACTIVE);

  // VSYNC is normalised to "blanking active = 1" before synchronising, so the
  // reset value of the chain always reads as inactive and never fakes an edge.
  logic        w_vs_raw;
  logic [10:0] w_level;
  logic [10:0] w_rise;
  logic [10:0] w_fall;
  logic        w_unused;

  assign w_vs_raw = (VS_ACTIVE_HIGH != 0) ? cam_vsync : ~cam_vsync;

  cam_sync_edge #(
    .W      (11),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (reset),
    .i_async ({w_vs_raw, cam_href, cam_pclk, cam_d}),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  logic [7:0] w_byte;
  logic       w_pclk_rise;
  logic       w_href;
  logic       w_href_fall;
  logic       w_vs_act;
  logic       w_vs_assert;
  logic       w_vs_deassert;

  assign w_byte        = w_level[7:0];
  assign w_pclk_rise   = w_rise[8];
  assign w_href        = w_level[9];
  assign w_href_fall   = w_fall[9];
  assign w_vs_act      = w_level[10];
  assign w_vs_assert   = w_rise[10];
  assign w_vs_deassert = w_fall[10];
  assign w_unused      = ^{w_rise[7:0], w_rise[9], w_fall[8:0]};

  cam_state_e     r_state;
  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           r_phase;
  logic [7:0]     r_hi;
  logic           r_pix_valid;
  rgb565_t        r_pix_data;
  logic [X_W-1:0] r_pix_x;
  logic [Y_W-1:0] r_pix_y;
  logic           r_sof;
  logic           r_eol;
  logic           r_frame_done;
  logic           r_line_err;

  // Capture FSM, byte pairing, coordinate counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_phase      <= 1'b0;
      r_hi         <= 8'h00;
      r_pix_valid  <= 1'b0;
      r_pix_data   <= '0;
      r_pix_x      <= '0;
      r_pix_y      <= '0;
      r_sof        <= 1'b0;
      r_eol        <= 1'b0;
      r_frame_done <= 1'b0;
      r_line_err   <= 1'b0;
    end else begin
      r_pix_valid  <= 1'b0;
      r_sof        <= 1'b0;
      r_eol        <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (enable) r_state <= ST_WAIT_VS;
          else        r_state <= ST_IDLE;
        end
        ST_WAIT_VS: begin
          // Only a blanking-to-active transition starts a frame, never mid-frame.
          if (w_vs_deassert) begin
            r_x     <= '0;
            r_y     <= '0;
            r_phase <= 1'b0;
            r_state <= ST_CAPTURE;
          end else begin
            r_state <= ST_WAIT_VS;
          end
        end
        ST_CAPTURE: begin
          if (w_vs_assert) begin
            // Frame ends; any partial line is abandoned without error.
            r_frame_done <= 1'b1;
            r_x          <= '0;
            r_phase      <= 1'b0;
            r_state      <= enable ? ST_WAIT_VS : ST_IDLE;
          end else if (w_href_fall) begin
            if (r_phase || ((r_x != '0) && (r_x < X_MAX))) r_line_err <= 1'b1;
            if ((r_x != '0) && (r_y < Y_MAX)) r_y <= r_y + Y_W'(1);
            r_x     <= '0;
            r_phase <= 1'b0;
          end else if (w_pclk_rise && w_href && !w_vs_act && (r_y < Y_MAX)) begin
            if (!r_phase) begin
              r_hi    <= w_byte;
              r_phase <= 1'b1;
            end else begin
              r_phase <= 1'b0;
              if (r_x < X_MAX) begin
                r_pix_valid <= 1'b1;
                r_pix_data  <= pack_rgb565(r_hi, w_byte);
                r_pix_x     <= r_x;
                r_pix_y     <= r_y;
                r_sof       <= (r_x == '0) && (r_y == '0);
                r_eol       <= (r_x == X_LAST);
                r_x         <= r_x + X_W'(1);
                if ((r_x == '0) && (r_y == '0)) r_line_err <= 1'b0;
              end else begin
                r_line_err <= 1'b1;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef CAM_CAPTURE_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [9:0]  r_last_line_cnt;

  // Frame statistics, updated on the same condition that pulses frame_done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_cnt     <= 16'h0000;
      r_last_line_cnt <= 10'd0;
    end else if ((r_state == ST_CAPTURE) && w_vs_assert) begin
      r_frame_cnt     <= r_frame_cnt + 16'd1;
      r_last_line_cnt <= 10'(r_y);
    end else begin
      r_frame_cnt     <= r_frame_cnt;
      r_last_line_cnt <= r_last_line_cnt;
    end
  end

  assign frame_cnt     = r_frame_cnt;
  assign last_line_cnt = r_last_line_cnt;
`endif

  assign pix_valid  = r_pix_valid;
  assign pix_data   = r_pix_data;
  assign pix_x      = r_pix_x;
  assign pix_y      = r_pix_y;
  assign sof        = r_sof;
  assign eol        = r_eol;
  assign frame_done = r_frame_done;
  assign line_err   = r_line_err;

endmodule
